mmio_input_port: RTL and testbench

- Memory-mapped input responder on the CPU data bus: the read-side counterpart of the write-only LED port.
- Synchronises and debounces 8 external pins (buttons/switches) and latches rising edges in a sticky W1C register.
- Returns register contents to the CPU over m_rd_data with the same 1-cycle read latency as data_mem.
- Sits beside data_mem and the LED port on cpu_clk; the SoC ORs its rd_data into m_rd_data, so rd_data is 0 when this block is not selected.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_input_port_if.sv | 15 +
 rtl/mmio_input_port_debounce_bit.sv | 46 ++++
 rtl/mmio_input_port.sv | 76 +++++++
 tb/tb_mmio_input_port.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared register offsets, ID constant and SoC base addresses for MMIO peripherals
package mmio_pkg;

   typedef enum logic [1:0] {
      OFF_LEVEL  = 2'd0,
      OFF_EDGE   = 2'd1,
      OFF_IRQ_EN = 2'd2,
      OFF_ID     = 2'd3
   } reg_off_e;

   localparam logic [7:0]  ID_VALUE        = 8'hA5;
   localparam logic [10:0] LED_BASE_ADDR   = 11'd15;
   localparam logic [10:0] INPUT_BASE_ADDR = 11'd16;

endpackage

// File: rtl/mmio_input_port_if.sv
// mmio_input_port_if: CPU data-bus slice seen by one memory-mapped responder
interface mmio_input_port_if;

   logic [10:0] m_addr;
   logic [7:0]  m_wr_data;
   logic        m_rd;
   logic        m_wr;
   logic        m_en;
   logic [7:0]  rd_data;
   logic        rd_hit;

   modport master (output m_addr, m_wr_data, m_rd, m_wr, m_en, input rd_data, rd_hit);
   modport slave  (input m_addr, m_wr_data, m_rd, m_wr, m_en, output rd_data, rd_hit);

endinterface

// File: rtl/mmio_input_port_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus tick-driven saturating debounce counter for one pin
module debounce_bit #(
   parameter int DB_LEN = 3
) (
   input  logic clk,
   input  logic reset_,
   input  logic tick,
   input  logic pin,
   output logic level,
   output logic rise
);

   localparam logic [2:0] LEN    = 3'(DB_LEN);
   localparam logic [2:0] LEN_M1 = 3'(DB_LEN - 1);

   logic [1:0] sync_q, sync_d;
   logic       level_q, level_d;
   logic [2:0] cnt_q, cnt_d;
   logic       differ, accept;

   // next-state: only the second sync stage feeds the debounce decision
   always_comb begin
      sync_d  = {sync_q[0], pin};
      differ  = sync_q[1] ^ level_q;
      accept  = tick & differ & (cnt_q == LEN_M1);
      cnt_d   = !tick ? cnt_q : (!differ || accept) ? 3'd0 : (cnt_q == LEN) ? cnt_q : cnt_q + 3'd1;
      level_d = accept ? sync_q[1] : level_q;
      rise    = accept & sync_q[1];
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/mmio_input_port.sv
// mmio_input_port: debounced 8-pin input responder with sticky W1C edge flags and level irq
module mmio_input_port
   import mmio_pkg::*;
#(
   parameter logic [10:0] BASE_ADDR = INPUT_BASE_ADDR,
   parameter int          DB_DIV    = 16,
   parameter int          DB_LEN    = 3
) (
   input  logic               clk,
   input  logic               reset_,
   mmio_input_port_if.slave   bus,
   input  logic [7:0]         pins,
   output logic               irq
);

   localparam int PW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DB_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    edge_q, edge_d;
   logic [7:0]    irq_en_q, irq_en_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_hit_q, rd_hit_d;
   logic [7:0]    level, rise, rd_mux, w1c;
   logic          tick, sel, rd, wr;
   reg_off_e      off;

   for (genvar i = 0; i < 8; i++) begin : g_db
      debounce_bit #(.DB_LEN(DB_LEN)) u_db (
         .clk   (clk),
         .reset_(reset_),
         .tick  (tick),
         .pin   (pins[i]),
         .level (level[i]),
         .rise  (rise[i])
      );
   end

   // decode, read mux and register next-state; edge set takes priority over W1C
   always_comb begin
      tick      = presc_q == PRESC_MAX;
      presc_d   = tick ? '0 : presc_q + 1'b1;
      sel       = bus.m_en & (bus.m_addr[10:2] == BASE_ADDR[10:2]);
      off       = reg_off_e'(bus.m_addr[1:0]);
      rd        = sel & bus.m_rd;
      wr        = sel & bus.m_wr;
      rd_mux    = (off == OFF_LEVEL) ? level : (off == OFF_EDGE) ? edge_q : (off == OFF_IRQ_EN) ? irq_en_q : ID_VALUE;
      w1c       = (wr && off == OFF_EDGE) ? bus.m_wr_data : 8'h00;
      edge_d    = (edge_q & ~w1c) | rise;
      irq_en_d  = (wr && off == OFF_IRQ_EN) ? bus.m_wr_data : irq_en_q;
      rd_data_d = rd ? rd_mux : 8'h00;
      rd_hit_d  = rd;
   end

   // register file, prescaler and registered read port
   always_ff @(posedge clk) begin
      if (!reset_) begin
         presc_q   <= '0;
         edge_q    <= '0;
         irq_en_q  <= '0;
         rd_data_q <= '0;
         rd_hit_q  <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         edge_q    <= edge_d;
         irq_en_q  <= irq_en_d;
         rd_data_q <= rd_data_d;
         rd_hit_q  <= rd_hit_d;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rd_hit  = rd_hit_q;
   assign irq         = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_mmio_input_port.sv
// tb_mmio_input_port: directed plus randomized checks against a behavioural model of the input port
module tb_mmio_input_port;

   localparam int DB_DIV = 16;
   localparam int DB_LEN = 3;
   localparam int BASE   = 16;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [7:0] pins = 8'h00;
   logic       irq;

   mmio_input_port_if bus_if();

   mmio_input_port #(.BASE_ADDR(11'(BASE)), .DB_DIV(DB_DIV), .DB_LEN(DB_LEN)) dut (
      .clk   (clk),
      .reset_(reset_),
      .bus   (bus_if),
      .pins  (pins),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [7:0] s1, s2, lvl, edg, ien, erd;
   logic       ehit;
   int         presc;
   int         run[8];

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
      end
   endtask

   task automatic model_step();
      int a, off;
      bit sel, tick;
      logic [7:0] rv, rs, clr;
      if (!reset_) begin
         s1 = 0; s2 = 0; lvl = 0; edg = 0; ien = 0; erd = 0; ehit = 0; presc = 0;
         for (int i = 0; i < 8; i++) run[i] = 0;
         return;
      end
      a   = int'(bus_if.m_addr);
      off = a % 4;
      sel = bus_if.m_en && (a / 4 == BASE / 4);
      rv  = off == 0 ? lvl : off == 1 ? edg : off == 2 ? ien : 8'hA5;
      erd  = (sel && bus_if.m_rd) ? rv : 8'h00;
      ehit = sel && bus_if.m_rd;
      tick  = presc == DB_DIV - 1;
      presc = (presc + 1) % DB_DIV;
      rs = 0;
      if (tick)
         for (int i = 0; i < 8; i++)
            if (s2[i] != lvl[i]) begin
               run[i]++;
               if (run[i] == DB_LEN) begin
                  lvl[i] = s2[i];
                  rs[i]  = s2[i];
                  run[i] = 0;
               end
            end else run[i] = 0;
      clr = (sel && bus_if.m_wr && off == 1) ? bus_if.m_wr_data : 8'h00;
      edg = (edg & ~clr) | rs;
      if (sel && bus_if.m_wr && off == 2) ien = bus_if.m_wr_data;
      s2 = s1;
      s1 = pins;
   endtask

   function automatic bit pred_rise1();
      return reset_ && presc == DB_DIV - 1 && s2[1] && !lvl[1] && run[1] == DB_LEN - 1;
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("rd_data", bus_if.rd_data, erd);
      chk("rd_hit", {7'd0, bus_if.rd_hit}, {7'd0, ehit});
      chk("irq", {7'd0, irq}, {7'd0, |(edg & ien)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic rd(input int addr, output logic [7:0] d, output logic h);
      bus_if.m_addr = 11'(addr); bus_if.m_en = 1; bus_if.m_rd = 1;
      cyc();
      d = bus_if.rd_data; h = bus_if.rd_hit;
      bus_if.m_en = 0; bus_if.m_rd = 0;
   endtask

   task automatic wr(input int addr, input logic [7:0] v);
      bus_if.m_addr = 11'(addr); bus_if.m_wr_data = v; bus_if.m_en = 1; bus_if.m_wr = 1;
      cyc();
      bus_if.m_en = 0; bus_if.m_wr = 0;
   endtask

   task automatic do_reset();
      reset_ = 0;
      idle(2);
      reset_ = 1;
   endtask

   initial begin
      logic [7:0] d;
      logic h;
      bit hit;
      bus_if.m_addr = 0; bus_if.m_wr_data = 0; bus_if.m_rd = 0; bus_if.m_wr = 0; bus_if.m_en = 0;
      #1;
      do_reset();
      chk("reset_irq", {7'd0, irq}, 8'h00);
      rd(BASE + 3, d, h);
      chk("id_data", d, 8'hA5);
      chk("id_hit", {7'd0, h}, 8'h01);
      rd(BASE + 4, d, h);
      chk("unsel_data", d, 8'h00);
      chk("unsel_hit", {7'd0, h}, 8'h00);

      for (int k = 0; k < 20; k++) begin
         pins = (k % 2 == 0) ? 8'h01 : 8'h00;
         idle(DB_DIV);
      end
      pins = 8'h00;
      idle(8);
      rd(BASE + 0, d, h);
      chk("bounce_level", d, 8'h00);
      rd(BASE + 1, d, h);
      chk("bounce_edge", d, 8'h00);

      do_reset();
      pins = 8'h01;
      for (int k = 0; k < 60; k++) rd(BASE + 0, d, h);
      chk("steady_level", d, 8'h01);
      rd(BASE + 1, d, h);
      chk("steady_edge", d, 8'h01);

      pins = 8'h03;
      idle(60);
      rd(BASE + 1, d, h);
      chk("edge03", d, 8'h03);
      wr(BASE + 1, 8'h01);
      rd(BASE + 1, d, h);
      chk("w1c_bit0", d, 8'h02);
      wr(BASE + 1, 8'h02);
      pins = 8'h01;
      idle(60);
      pins = 8'h03;
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++)
         if (pred_rise1()) begin
            hit = 1;
            wr(BASE + 1, 8'h02);
         end else cyc();
      chk("rise_found", {7'd0, hit}, 8'h01);
      rd(BASE + 1, d, h);
      chk("set_wins", d, 8'h02);

      pins = 8'h01;
      do_reset();
      idle(60);
      rd(BASE + 1, d, h);
      chk("edge01", d, 8'h01);
      wr(BASE + 2, 8'h02);
      cyc();
      chk("irq_masked", {7'd0, irq}, 8'h00);
      pins = 8'h03;
      idle(60);
      chk("irq_on", {7'd0, irq}, 8'h01);
      wr(BASE + 1, 8'h02);
      chk("irq_off", {7'd0, irq}, 8'h00);

      pins = 8'h00;
      idle(60);
      pins = 8'hFF;
      idle(20);
      bus_if.m_addr = 11'(BASE + 3); bus_if.m_en = 1; bus_if.m_rd = 1;
      reset_ = 0;
      cyc();
      bus_if.m_en = 0; bus_if.m_rd = 0;
      reset_ = 1;
      chk("rst_hit", {7'd0, bus_if.rd_hit}, 8'h00);
      chk("rst_data", bus_if.rd_data, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      for (int o = 0; o < 3; o++) begin
         rd(BASE + o, d, h);
         chk("rst_reg", d, 8'h00);
      end
      idle(60);
      rd(BASE + 1, d, h);
      chk("redetect", d, 8'hFF);

      for (int k = 0; k < 3000; k++) begin
         bus_if.m_en      = 1'($urandom_range(0, 3) != 0);
         bus_if.m_addr    = ($urandom_range(0, 4) == 0) ? 11'($urandom) : 11'(BASE + $urandom_range(0, 3));
         bus_if.m_rd      = 1'($urandom);
         bus_if.m_wr      = 1'($urandom_range(0, 3) == 0);
         bus_if.m_wr_data = 8'($urandom);
         if ($urandom_range(0, 120) == 0) pins = pins ^ 8'($urandom);
         reset_ = $urandom_range(0, 700) != 0;
         cyc();
      end
      reset_ = 1; bus_if.m_en = 0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
